sentinel_auth_ctrl: RTL and testbench
=====================================

Name: sentinel_auth_ctrl

Overview:
- Sequencing controller for the Sentinel key comparator datapath, i.e. the XNOR-per-bit and AND4/AND2 reduction tree.
- Accepts a candidate key over a valid/ready handshake, holds it on the comparator inputs, and strobes and samples the comparator's match result.
- Issues a timed grant pulse, or counts failures and enforces a timed lockout after MAX_FAIL consecutive misses.
- Sits between the chip I/O front end and the comparator; the comparator stays purely combinational.

Parameters:
- KEY_W, 8, candidate key width in bits; must equal the comparator width.
- MAX_FAIL, 3, consecutive failed compares that trigger lockout; range 1..15.
- GRANT_CYCLES, 8, cycles the granted output stays high; must be at least 1.
- LOCK_CYCLES, 16, cycles spent in lockout; must be at least 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- r  in  1  asynchronous active-high reset (Tactical Wipe).
- key_in  in  KEY_W  candidate key.
- key_valid  in  1  candidate key present.
- key_ready  out  1  controller can accept a key.
- wipe  in  1  synchronous abort; clears the held key.
- cmp_key  out  KEY_W  held key driven to the comparator A inputs.
- cmp_en  out  1  compare strobe, high for exactly one cycle.
- cmp_match  in  1  comparator result; combinational, valid while cmp_en is high.
- granted  out  1  access granted.
- denied  out  1  one-cycle reject pulse.
- locked  out  1  lockout active.
- fail_count  out  4  current consecutive-failure count.

Behaviour:
- Interface (already decided): one clock, clk; reset r is asynchronous and active-high.
- Reset values: all outputs 0 except key_ready=1; state IDLE; cmp_key=0; fail_count=0; timer=0. Reset asserted mid-operation aborts immediately to these values.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- States: IDLE, COMPARE, GRANT, DENY, LOCKOUT. Encodings are localparams.
- IDLE:
  - key_ready=1.
  - On key_valid & key_ready: cmp_key <= key_in; go to COMPARE.
  - key_valid held high is accepted once per return to IDLE.
- COMPARE (exactly 1 cycle):
  - cmp_en=1, key_ready=0; cmp_match is sampled at the closing edge.
  - If match: go to GRANT; fail_count <= 0; timer <= GRANT_CYCLES-1.
  - If miss and fail_count+1 == MAX_FAIL: go to LOCKOUT; timer <= LOCK_CYCLES-1; fail_count <= MAX_FAIL.
  - Otherwise on miss: go to DENY; fail_count <= fail_count+1.
- GRANT:
  - granted=1 for exactly GRANT_CYCLES cycles; the timer decrements each cycle.
  - At timer==0: go to IDLE; cmp_key <= 0.
- DENY:
  - denied=1 for 1 cycle, then go to IDLE; cmp_key <= 0.
- LOCKOUT:
  - locked=1, key_ready=0; key_valid is ignored and any offered key is not consumed.
  - Lasts exactly LOCK_CYCLES cycles. On exit go to IDLE; fail_count <= 0; cmp_key <= 0.
- Handshake to comparator latency: accept edge to cmp_en high is 1 cycle; accept edge to granted/denied/locked high is 2 cycles.
- wipe:
  - In IDLE, COMPARE, GRANT or DENY: next state IDLE, cmp_key <= 0, granted and denied drop; the compare result is discarded.
  - wipe has priority over key acceptance and over the compare result in the same cycle.
  - wipe never alters fail_count, so a wipe cannot bypass lockout.
  - wipe is ignored in LOCKOUT.
- Counter widths:
  - Timer width is $clog2(max(GRANT_CYCLES, LOCK_CYCLES)).
  - fail_count saturates at MAX_FAIL and never wraps.
- A successful grant clears accumulated failures; only consecutive misses lock.

Decomposition:
- Shared package/header citadel_auth_pkg holds:
  - state localparams ST_IDLE, ST_COMPARE, ST_GRANT, ST_DENY, ST_LOCKOUT, as 3-bit binary;
  - the default KEY_W;
  - the fail_count width constant FAIL_W=4.
- One sub-module, sentinel_down_timer: loadable down-counter with load, load_value, tick enable and zero flag, shared by GRANT and LOCKOUT.
- The comparator itself is not instantiated here; it is wired alongside at the parent level.

Test Plan (bench comparator matches cmp_key == 8'hA5; defaults):
- Reset then key 8'hA5 offered: key_ready drops; cmp_en pulses 1 cycle after accept; granted high for exactly 8 cycles starting 2 cycles after accept; cmp_key=0 afterwards; fail_count=0.
- Keys 8'h00 then 8'h01: each gives a 1-cycle denied pulse, with fail_count 1 then 2; key_ready returns 1 cycle after each denied.
- Third miss 8'hFF: locked high for 16 cycles; key 8'hA5 held valid throughout is not accepted (key_ready=0); after exit fail_count=0 and the still-valid 8'hA5 is accepted and grants.
- Two misses, then 8'hA5 grant, then one miss: fail_count reads 2, 0, 1; no lockout.
- wipe asserted during the COMPARE cycle of 8'hA5: no granted; IDLE next cycle; cmp_key=0. wipe during GRANT cycle 3: granted drops next cycle. wipe during LOCKOUT: no effect, lockout still lasts 16 cycles.
- r pulsed asynchronously mid-LOCKOUT and mid-GRANT: outputs reach reset values without waiting for a clock edge; fail_count=0; the next 8'hA5 grants normally.

Source files
------------

// File: rtl/citadel_auth_pkg.sv
// citadel_auth_pkg: shared state encodings and widths for the Sentinel auth controller
package citadel_auth_pkg;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_COMPARE = 3'd1;
    localparam state_t ST_GRANT   = 3'd2;
    localparam state_t ST_DENY    = 3'd3;
    localparam state_t ST_LOCKOUT = 3'd4;
    localparam int DEF_KEY_W = 8;
    localparam int FAIL_W    = 4;
endpackage

// File: rtl/sentinel_down_timer.sv
// sentinel_down_timer: loadable down-counter that stops at zero, shared by grant and lockout
module sentinel_down_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         tick,
    output logic         zero
);
    logic [W-1:0] count;
    // load wins over tick; counting stops at zero so an idle timer never wraps
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (load) count <= load_value;
        else if (tick && count != '0) count <= count - W'(1);
    assign zero = count == '0;
endmodule

// File: rtl/sentinel_auth_ctrl.sv
// sentinel_auth_ctrl: sequences key compare, timed grant, failure counting and lockout
module sentinel_auth_ctrl
    import citadel_auth_pkg::*;
#(
    parameter int KEY_W        = DEF_KEY_W,
    parameter int MAX_FAIL     = 3,
    parameter int GRANT_CYCLES = 8,
    parameter int LOCK_CYCLES  = 16
) (
    input  logic              clk,
    input  logic              r,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic              wipe,
    output logic [KEY_W-1:0]  cmp_key,
    output logic              cmp_en,
    input  logic              cmp_match,
    output logic              granted,
    output logic              denied,
    output logic              locked,
    output logic [FAIL_W-1:0] fail_count
);
    localparam int MAX_CYC = GRANT_CYCLES > LOCK_CYCLES ? GRANT_CYCLES : LOCK_CYCLES;
    localparam int TW      = MAX_CYC > 1 ? $clog2(MAX_CYC) : 1;
    state_t            state, state_nx;
    logic [KEY_W-1:0]  key_nx;
    logic [FAIL_W-1:0] fail_nx;
    logic              tmr_load, tmr_zero;
    logic [TW-1:0]     tmr_value;
    logic              last_miss;
    assign last_miss = fail_count + FAIL_W'(1) == FAIL_W'(MAX_FAIL);
    sentinel_down_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (r),
        .load       (tmr_load),
        .load_value (tmr_value),
        .tick       (state == ST_GRANT || state == ST_LOCKOUT),
        .zero       (tmr_zero)
    );
    // next state, held key and failure count; wipe beats acceptance and compare result
    always_comb begin
        state_nx  = state;
        key_nx    = cmp_key;
        fail_nx   = fail_count;
        tmr_load  = 1'b0;
        tmr_value = TW'(GRANT_CYCLES - 1);
        case (state)
            ST_IDLE:
                if (wipe) key_nx = '0;
                else if (key_valid) begin
                    state_nx = ST_COMPARE;
                    key_nx   = key_in;
                end
            ST_COMPARE:
                if (wipe) begin
                    state_nx = ST_IDLE;
                    key_nx   = '0;
                end else if (cmp_match) begin
                    state_nx = ST_GRANT;
                    fail_nx  = '0;
                    tmr_load = 1'b1;
                end else if (last_miss) begin
                    state_nx  = ST_LOCKOUT;
                    fail_nx   = FAIL_W'(MAX_FAIL);
                    tmr_load  = 1'b1;
                    tmr_value = TW'(LOCK_CYCLES - 1);
                end else begin
                    state_nx = ST_DENY;
                    fail_nx  = fail_count + FAIL_W'(1);
                end
            ST_GRANT:
                if (wipe || tmr_zero) begin
                    state_nx = ST_IDLE;
                    key_nx   = '0;
                end
            ST_LOCKOUT:
                if (tmr_zero) begin
                    state_nx = ST_IDLE;
                    key_nx   = '0;
                    fail_nx  = '0;
                end
            default: begin
                state_nx = ST_IDLE;
                key_nx   = '0;
            end
        endcase
    end
    // state, held key and failure count; Tactical Wipe reset clears everything at once
    always_ff @(posedge clk or posedge r)
        if (r) begin
            state      <= ST_IDLE;
            cmp_key    <= '0;
            fail_count <= '0;
        end else begin
            state      <= state_nx;
            cmp_key    <= key_nx;
            fail_count <= fail_nx;
        end
    assign key_ready = state == ST_IDLE;
    assign cmp_en    = state == ST_COMPARE;
    assign granted   = state == ST_GRANT;
    assign denied    = state == ST_DENY;
    assign locked    = state == ST_LOCKOUT;
endmodule

// File: tb/tb_sentinel_auth_ctrl.sv
// tb_sentinel_auth_ctrl: directed and random stimulus against a schedule-queue reference model
module tb_sentinel_auth_ctrl;
    localparam int MAXF = 3;
    localparam int GC   = 8;
    localparam int LC   = 16;
    logic       clk = 1'b0;
    logic       r = 1'b1;
    logic       key_valid = 1'b0;
    logic       wipe = 1'b0;
    logic [7:0] key_in = 8'h00;
    logic       key_ready, cmp_en, cmp_match, granted, denied, locked;
    logic [7:0] cmp_key;
    logic [3:0] fail_count;
    int         checks = 0;
    int         errors = 0;
    always #5 clk = ~clk;
    assign cmp_match = cmp_key == 8'hA5;
    sentinel_auth_ctrl dut (
        .clk        (clk),
        .r          (r),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .wipe       (wipe),
        .cmp_key    (cmp_key),
        .cmp_en     (cmp_en),
        .cmp_match  (cmp_match),
        .granted    (granted),
        .denied     (denied),
        .locked     (locked),
        .fail_count (fail_count)
    );
    // each queued entry is what the outputs must show for one future cycle
    typedef struct packed {
        logic       c;
        logic       g;
        logic       d;
        logic       l;
        logic [7:0] k;
        logic [3:0] f;
    } ent_t;
    ent_t q[$];
    int   idle_f = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic check_all();
        ent_t e;
        logic busy;
        busy = q.size() != 0;
        e = busy ? q[0] : '0;
        chk("key_ready", 32'(key_ready), 32'(!busy));
        chk("cmp_en", 32'(cmp_en), 32'(e.c));
        chk("granted", 32'(granted), 32'(e.g));
        chk("denied", 32'(denied), 32'(e.d));
        chk("locked", 32'(locked), 32'(e.l));
        chk("cmp_key", 32'(cmp_key), 32'(e.k));
        chk("fail_count", 32'(fail_count), busy ? 32'(e.f) : 32'(idle_f));
    endtask
    task automatic accept(input logic [7:0] k);
        ent_t e;
        int   f;
        f = idle_f;
        e = '0;
        e.c = 1'b1;
        e.k = k;
        e.f = 4'(f);
        q.push_back(e);
        e.c = 1'b0;
        if (k == 8'hA5) begin
            e.g = 1'b1;
            e.f = 4'd0;
            repeat (GC) q.push_back(e);
        end else if (f + 1 == MAXF) begin
            e.l = 1'b1;
            e.f = 4'(MAXF);
            repeat (LC) q.push_back(e);
        end else begin
            e.d = 1'b1;
            e.f = 4'(f + 1);
            q.push_back(e);
        end
    endtask
    task automatic cyc(input logic v, input logic [7:0] k, input logic w);
        @(negedge clk);
        check_all();
        key_valid = v;
        key_in = k;
        wipe = w;
        @(posedge clk);
        if (q.size() != 0) begin
            if (w && !q[0].l) begin
                idle_f = int'(q[0].f);
                q.delete();
            end else begin
                idle_f = q[0].l ? 0 : int'(q[0].f);
                void'(q.pop_front());
            end
        end else if (v && !w) accept(k);
    endtask
    task automatic run(input logic v, input logic [7:0] k, input logic w, input int n);
        repeat (n) cyc(v, k, w);
    endtask
    task automatic areset();
        @(negedge clk);
        check_all();
        key_valid = 1'b0;
        wipe = 1'b0;
        #2 r = 1'b1;
        #1;
        q.delete();
        idle_f = 0;
        check_all();
        r = 1'b0;
        @(posedge clk);
        if (q.size() != 0) void'(q.pop_front());
    endtask
    task automatic three_misses();
        run(1'b1, 8'h00, 1'b0, 1);
        run(1'b0, 8'h00, 1'b0, 3);
        run(1'b1, 8'h01, 1'b0, 1);
        run(1'b0, 8'h00, 1'b0, 3);
        run(1'b1, 8'hFF, 1'b0, 1);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        check_all();
        r = 1'b0;
        run(1'b1, 8'hA5, 1'b0, 1);
        run(1'b0, 8'h00, 1'b0, 12);
        three_misses();
        run(1'b1, 8'hA5, 1'b0, 30);
        run(1'b0, 8'h00, 1'b0, 12);
        run(1'b1, 8'h00, 1'b0, 1);
        run(1'b0, 8'h00, 1'b0, 3);
        run(1'b1, 8'h11, 1'b0, 1);
        run(1'b0, 8'h00, 1'b0, 3);
        run(1'b1, 8'hA5, 1'b0, 1);
        run(1'b0, 8'h00, 1'b0, 10);
        run(1'b1, 8'h22, 1'b0, 1);
        run(1'b0, 8'h00, 1'b0, 3);
        run(1'b1, 8'hA5, 1'b0, 1);
        run(1'b0, 8'h00, 1'b0, 10);
        run(1'b1, 8'hA5, 1'b0, 1);
        run(1'b0, 8'h00, 1'b1, 1);
        run(1'b0, 8'h00, 1'b0, 3);
        run(1'b1, 8'hA5, 1'b0, 1);
        run(1'b0, 8'h00, 1'b0, 3);
        run(1'b0, 8'h00, 1'b1, 1);
        run(1'b0, 8'h00, 1'b0, 3);
        three_misses();
        run(1'b0, 8'h00, 1'b0, 3);
        run(1'b1, 8'hA5, 1'b1, 2);
        run(1'b0, 8'h00, 1'b0, 20);
        three_misses();
        run(1'b0, 8'h00, 1'b0, 6);
        areset();
        run(1'b1, 8'hA5, 1'b0, 1);
        run(1'b0, 8'h00, 1'b0, 10);
        run(1'b1, 8'hA5, 1'b0, 1);
        run(1'b0, 8'h00, 1'b0, 4);
        areset();
        run(1'b1, 8'hA5, 1'b0, 1);
        run(1'b0, 8'h00, 1'b0, 10);
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] k;
            k = 8'($urandom);
            if ($urandom_range(0, 3) == 0) k = 8'hA5;
            cyc(1'($urandom_range(0, 1)), k, $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) areset();
        end
        run(1'b0, 8'h00, 1'b0, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
